mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU control unit's memory strobes (mem_read/mem_write/mem2bus/bus2mem).
//  Owns the program/data store and serves it three ways, selected by cpustate:
//   IN: loads a program from an external byte stream. CHECK: streams the stored bytes back out.
//   RUN: answers CPU reads combinationally and commits CPU writes on the clock edge.
// PARAMETERS
//  DW      8    data width (bytes on the CPU bus)
//  ADDR_W  16   CPU address width (AR width)
//  MEM_AW  8    implemented address bits; DEPTH = 2**MEM_AW words
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous active-low reset
//  cpustate    in   2       00 IDLE, 01 IN, 10 CHECK, 11 RUN
//  addr        in   ADDR_W  CPU address (from AR)
//  mem_read    in   1       CPU read strobe
//  mem2bus     in   1       CPU enables memory onto the bus
//  mem_write   in   1       CPU write strobe
//  bus2mem     in   1       CPU enables bus into memory
//  bus_in      in   DW      CPU bus write data
//  bus_out     out  DW      read data to the CPU bus
//  ld_valid    in   1       loader byte valid (IN)
//  ld_data     in   DW      loader byte
//  ld_ready    out  1       loader byte accepted when ld_valid && ld_ready
//  chk_valid   out  1       readback byte valid (CHECK)
//  chk_data    out  DW      readback byte
//  chk_ready   in   1       readback consumer ready
//  chk_done    out  1       all loaded bytes have been streamed
//  load_count  out  MEM_AW+1  number of bytes loaded since the last entry into IN
//  prot_err    out  1       one-cycle pulse on a blocked write (MEM_WRPROT_EN only; otherwise tied to 0)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in S_IDLE; ld_ptr, chk_ptr and load_count = 0. Array contents are not reset.
//  FSM states: S_IDLE, S_LOAD, S_CHECK, S_RUN.
//   - The state register follows cpustate with one cycle of latency.
//   - Any state change aborts the operation in progress with no partial handshake.
//   - Entering S_LOAD clears ld_ptr and load_count.
//   - Entering S_CHECK clears chk_ptr and chk_done, and drops chk_valid.
//  S_LOAD:
//   - ld_ready = (ld_ptr < DEPTH).
//   - On accept: mem[ld_ptr] <= ld_data; ld_ptr++ and load_count++ in the same edge.
//   - At ld_ptr == DEPTH, ld_ready stays 0 (saturates, no wrap); further ld_valid is ignored.
//  S_CHECK:
//   - Registered output, 1-cycle latency from pointer to chk_data.
//   - chk_valid and chk_data hold stable until chk_ready.
//   - On each handshake chk_ptr advances; back-to-back transfers give 1 byte/cycle.
//   - When chk_ptr reaches load_count, chk_valid drops and chk_done is set and held.
//   - load_count == 0: chk_done is set 1 cycle after entry and no byte is emitted.
//  S_RUN:
//   - bus_out = mem[addr[MEM_AW-1:0]] combinationally when mem_read && mem2bus; otherwise 0.
//   - Write: mem[addr] <= bus_in on the edge where mem_write && bus2mem.
//   - Out of range (addr[ADDR_W-1:MEM_AW] != 0): reads return 0; writes are dropped.
//   - Read and write in the same cycle: bus_out shows pre-write data; the write commits.
//  In non-RUN states, CPU strobes are ignored and bus_out = 0.
//  Mid-operation reset: immediate return to reset values; loaded contents survive, load_count is lost.
// CONFIGURATION
//  MEM_WRPROT_EN defined:
//   - RUN writes to addresses < load_count are blocked (program protected).
//   - A blocked write pulses prot_err for 1 cycle and leaves memory unchanged.
//   - Out-of-range writes also pulse prot_err.
//  MEM_WRPROT_EN undefined: every in-range RUN write commits; prot_err is constant 0.
// STRUCTURE
//  Shared package cpu_pkg:
//   - cpustate encodings (CPU_IDLE/IN/CHECK/RUN) and the mem_responder state encodings.
//   - Default DW/ADDR_W.
//  One sub-module, mem_array: DEPTH x DW array, one synchronous write port, two asynchronous read ports (CPU, CHECK).
//   - Write-port mux (loader vs CPU) is selected by FSM state and lives in mem_responder.
// TESTING
//  1. Reset mid-load: apply rst=0 with ld_valid high -> all outputs 0 next cycle; after release, FSM in S_IDLE.
//  2. IN: 4 bytes A5,3C,00,FF with ld_valid held, one stall cycle -> load_count=4; mem[0..3] matches.
//  3. CHECK with chk_ready toggled 1,0,1,1,1 -> chk_data A5,3C,00,FF each held stable while stalled.
//     Then chk_done=1 and chk_valid=0.
//  4. IN with DEPTH+2 bytes -> ld_ready drops after byte DEPTH; load_count=DEPTH; no wrap overwrite of mem[0].
//  5. RUN: write 5A to addr 0x0010, then read it back -> bus_out=5A in the read cycle.
//     Read of 0x0100 -> 00; write to 0x0100 is dropped.
//  6. MEM_WRPROT_EN on, load_count=4: write to 0x0002 -> prot_err pulse, mem unchanged; write to 0x0004 commits.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: cpustate encodings, mem_responder FSM states and default widths.
package cpu_pkg;

    localparam int DW_DEFAULT     = 8;
    localparam int ADDR_W_DEFAULT = 16;
    localparam int MEM_AW_DEFAULT = 8;

    localparam logic [1:0] CPU_IDLE  = 2'b00;
    localparam logic [1:0] CPU_IN    = 2'b01;
    localparam logic [1:0] CPU_CHECK = 2'b10;
    localparam logic [1:0] CPU_RUN   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_CHECK = 2'b10,
        S_RUN   = 2'b11
    } mr_state_e;

    function automatic mr_state_e cpustate_to_state(input logic [1:0] cs);
        case (cs)
            CPU_IN:    return S_LOAD;
            CPU_CHECK: return S_CHECK;
            CPU_RUN:   return S_RUN;
            default:   return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of CPU strobes, loader stream and readback stream served by mem_responder.
interface mem_responder_if import cpu_pkg::*; #(
    parameter int DW     = DW_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT
);
    logic [1:0]        cpustate;
    logic [ADDR_W-1:0] addr;
    logic              mem_read;
    logic              mem2bus;
    logic              mem_write;
    logic              bus2mem;
    logic [DW-1:0]     bus_in;
    logic [DW-1:0]     bus_out;
    logic              ld_valid;
    logic [DW-1:0]     ld_data;
    logic              ld_ready;
    logic              chk_valid;
    logic [DW-1:0]     chk_data;
    logic              chk_ready;
    logic              chk_done;
    logic [MEM_AW:0]   load_count;
    logic              prot_err;

    modport slave (
        input  cpustate, addr, mem_read, mem2bus, mem_write, bus2mem, bus_in,
               ld_valid, ld_data, chk_ready,
        output bus_out, ld_ready, chk_valid, chk_data, chk_done, load_count, prot_err
    );

    modport master (
        output cpustate, addr, mem_read, mem2bus, mem_write, bus2mem, bus_in,
               ld_valid, ld_data, chk_ready,
        input  bus_out, ld_ready, chk_valid, chk_data, chk_done, load_count, prot_err
    );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DW storage: one synchronous write port, asynchronous CPU and CHECK read ports.
module mem_array #(
    parameter int DW     = 8,
    parameter int MEM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [MEM_AW-1:0] i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [MEM_AW-1:0] i_cpu_raddr,
    output logic [DW-1:0]     o_cpu_rdata,
    input  logic [MEM_AW-1:0] i_chk_raddr,
    output logic [DW-1:0]     o_chk_rdata
);

    // Contents deliberately have no reset so a loaded program survives a reset.
    logic [DW-1:0] r_mem [0:(1<<MEM_AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_cpu_rdata = r_mem[i_cpu_raddr];
    assign o_chk_rdata = r_mem[i_chk_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: program load (IN), readback stream (CHECK), CPU read/write (RUN).
// Optional MEM_WRPROT_EN blocks RUN writes into the loaded program region and flags them on prot_err.
module mem_responder import cpu_pkg::*; #(
    parameter int DW     = DW_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input logic            i_clk,
    input logic            i_rst_n,
    mem_responder_if.slave mem_if
);

    localparam logic [MEM_AW:0] DEPTH_CNT = {1'b1, {MEM_AW{1'b0}}};

    mr_state_e         r_state;
    mr_state_e         w_next;
    // ld_ptr and load_count always move together, so one register serves both.
    logic [MEM_AW:0]   r_ld_ptr;
    logic [MEM_AW:0]   r_chk_ptr;
    logic              r_chk_valid;
    logic              r_chk_done;
    logic [DW-1:0]     r_chk_data;

    logic              w_in_range;
    logic              w_ld_ready;
    logic              w_ld_accept;
    logic              w_cpu_wr_req;
    logic              w_prot_block;
    logic              w_cpu_we;
    logic              w_we;
    logic [MEM_AW-1:0] w_waddr;
    logic [DW-1:0]     w_wdata;
    logic [DW-1:0]     w_cpu_rdata;
    logic [DW-1:0]     w_chk_rdata;
    logic [DW-1:0]     w_bus_out;
    logic              w_chk_entry;

    assign w_in_range = (mem_if.addr[ADDR_W-1:MEM_AW] == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = cpustate_to_state(mem_if.cpustate);
        w_ld_ready   = 1'b0;
        w_ld_accept  = 1'b0;
        w_cpu_wr_req = 1'b0;
        w_bus_out    = '0;
        case (r_state)
            S_LOAD: begin
                w_ld_ready  = (r_ld_ptr < DEPTH_CNT);
                w_ld_accept = w_ld_ready && mem_if.ld_valid;
            end
            S_RUN: begin
                if (mem_if.mem_read && mem_if.mem2bus && w_in_range) begin
                    w_bus_out = w_cpu_rdata;
                end
                w_cpu_wr_req = mem_if.mem_write && mem_if.bus2mem;
            end
            default: ;
        endcase
    end

`ifdef MEM_WRPROT_EN
    logic r_prot_err;

    assign w_prot_block = w_cpu_wr_req &&
        (!w_in_range || ({{(ADDR_W-MEM_AW-1){1'b0}}, r_ld_ptr} > mem_if.addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prot_err <= 1'b0;
        end else begin
            r_prot_err <= w_prot_block;
        end
    end

    assign mem_if.prot_err = r_prot_err;
`else
    assign w_prot_block    = 1'b0;
    assign mem_if.prot_err = 1'b0;
`endif

    // The write port belongs to the loader in S_LOAD and to the CPU otherwise.
    assign w_cpu_we = w_cpu_wr_req && w_in_range && !w_prot_block;
    assign w_we     = w_ld_accept || w_cpu_we;
    assign w_waddr  = (r_state == S_LOAD) ? r_ld_ptr[MEM_AW-1:0] : mem_if.addr[MEM_AW-1:0];
    assign w_wdata  = (r_state == S_LOAD) ? mem_if.ld_data : mem_if.bus_in;

    mem_array #(
        .DW     (DW),
        .MEM_AW (MEM_AW)
    ) u_mem_array (
        .i_clk       (i_clk),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_cpu_raddr (mem_if.addr[MEM_AW-1:0]),
        .o_cpu_rdata (w_cpu_rdata),
        .i_chk_raddr (r_chk_ptr[MEM_AW-1:0]),
        .o_chk_rdata (w_chk_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_ptr <= '0;
        end else if (w_next == S_LOAD && r_state != S_LOAD) begin
            r_ld_ptr <= '0;
        end else if (w_ld_accept) begin
            r_ld_ptr <= r_ld_ptr + 1'b1;
        end
    end

    assign w_chk_entry = (w_next == S_CHECK) && (r_state != S_CHECK);

    // r_chk_ptr is the fetch pointer: it runs one ahead of the byte currently presented.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chk_ptr   <= '0;
            r_chk_valid <= 1'b0;
            r_chk_done  <= 1'b0;
            r_chk_data  <= '0;
        end else if (w_chk_entry) begin
            r_chk_ptr   <= '0;
            r_chk_valid <= 1'b0;
            r_chk_done  <= 1'b0;
        end else if (w_next != S_CHECK) begin
            r_chk_valid <= 1'b0;
        end else if (!r_chk_done && (!r_chk_valid || mem_if.chk_ready)) begin
            if (r_chk_ptr < r_ld_ptr) begin
                r_chk_data  <= w_chk_rdata;
                r_chk_valid <= 1'b1;
                r_chk_ptr   <= r_chk_ptr + 1'b1;
            end else begin
                r_chk_valid <= 1'b0;
                r_chk_done  <= 1'b1;
            end
        end
    end

    assign mem_if.bus_out    = w_bus_out;
    assign mem_if.ld_ready   = w_ld_ready;
    assign mem_if.chk_valid  = r_chk_valid;
    assign mem_if.chk_data   = r_chk_data;
    assign mem_if.chk_done   = r_chk_done;
    assign mem_if.load_count = r_ld_ptr;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: array reference model, queued expectations, negedge monitor.
module tb_mem_responder;
    import cpu_pkg::*;

    localparam int DW     = 8;
    localparam int ADDR_W = 16;
    localparam int MEM_AW = 8;
    localparam int DEPTH  = 1 << MEM_AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_responder_if #(.DW(DW), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) memIf ();

    mem_responder #(.DW(DW), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .mem_if  (memIf)
    );

    int refMem [DEPTH];
    int loadCount = 0;
    bit inRun     = 1'b0;
    int chkQ [$];
    int rdQ [$];
    int checks    = 0;
    int errors    = 0;
    int monExp;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor pops the next expectation whenever the DUT hands over a byte or a CPU read is strobed.
    always @(negedge clk) begin
        if (rst_n && memIf.chk_valid && memIf.chk_ready) begin
            if (chkQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL chk_extra actual=%0h required=none", memIf.chk_data);
            end else begin
                monExp = chkQ.pop_front();
                checkOutput("chk_data", {24'd0, memIf.chk_data}, monExp);
            end
        end
        if (memIf.mem_read && memIf.mem2bus) begin
            if (rdQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_extra actual=%0h required=none", memIf.bus_out);
            end else begin
                monExp = rdQ.pop_front();
                checkOutput("bus_out", {24'd0, memIf.bus_out}, monExp);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ld_ready"}, {31'd0, memIf.ld_ready}, 0);
        checkOutput({tag, "_chk_valid"}, {31'd0, memIf.chk_valid}, 0);
        checkOutput({tag, "_chk_done"}, {31'd0, memIf.chk_done}, 0);
        checkOutput({tag, "_chk_data"}, {24'd0, memIf.chk_data}, 0);
        checkOutput({tag, "_load_count"}, {23'd0, memIf.load_count}, 0);
        checkOutput({tag, "_bus_out"}, {24'd0, memIf.bus_out}, 0);
        checkOutput({tag, "_prot_err"}, {31'd0, memIf.prot_err}, 0);
    endtask

    task automatic enterLoad();
        memIf.cpustate = CPU_IN;
        memIf.ld_valid = 1'b0;
        inRun = 1'b0;
        tick();
        loadCount = 0;
    endtask

    task automatic loadCycle(input bit v, input logic [7:0] d);
        bit expReady;
        memIf.ld_valid = v;
        memIf.ld_data  = d;
        expReady = (loadCount < DEPTH);
        @(negedge clk);
        checkOutput("ld_ready", {31'd0, memIf.ld_ready}, {31'd0, expReady});
        checkOutput("load_count", {23'd0, memIf.load_count}, loadCount);
        if (v && expReady) begin
            refMem[loadCount] = d;
            loadCount++;
        end
        tick();
        memIf.ld_valid = 1'b0;
    endtask

    task automatic doCheck(input bit usePattern);
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int idx = 0;
        bit done = 1'b0;
        memIf.cpustate  = CPU_CHECK;
        memIf.chk_ready = 1'b0;
        inRun = 1'b0;
        for (int i = 0; i < loadCount; i++) chkQ.push_back(refMem[i]);
        tick();
        for (int c = 0; c < loadCount * 4 + 20 && !done; c++) begin
            if (usePattern && idx < 5) begin
                memIf.chk_ready = pat[idx];
                if (memIf.chk_valid) idx++;
            end else begin
                memIf.chk_ready = usePattern ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (memIf.chk_done) done = 1'b1;
            tick();
        end
        checkOutput("chk_done_reached", {31'd0, done}, 1);
        checkOutput("chk_valid_after_done", {31'd0, memIf.chk_valid}, 0);
        checkOutput("chk_queue_drained", chkQ.size(), 0);
        memIf.chk_ready = 1'b0;
    endtask

    task automatic enterRun();
        memIf.cpustate = CPU_RUN;
        tick();
        inRun = 1'b1;
    endtask

    // One CPU bus cycle; the model decides read data, write commit and protection from the rules.
    task automatic cpuCycle(input bit rd, input bit wr, input int a, input int d);
        bit inRange = (a < DEPTH);
        bit prot = 1'b0;
`ifdef MEM_WRPROT_EN
        prot = inRun && wr && (!inRange || a < loadCount);
`endif
        memIf.addr      = ADDR_W'(a);
        memIf.bus_in    = DW'(d);
        memIf.mem_read  = rd;
        memIf.mem2bus   = rd;
        memIf.mem_write = wr;
        memIf.bus2mem   = wr;
        if (rd) rdQ.push_back((inRun && inRange) ? refMem[a] : 0);
        @(negedge clk);
        @(posedge clk);
        if (inRun && wr && inRange && !prot) refMem[a] = d & 8'hFF;
        #1;
        memIf.mem_read  = 1'b0;
        memIf.mem2bus   = 1'b0;
        memIf.mem_write = 1'b0;
        memIf.bus2mem   = 1'b0;
        @(negedge clk);
        checkOutput("prot_err", {31'd0, memIf.prot_err}, {31'd0, prot});
        tick();
    endtask

    task automatic applyStimulus();
        int a;
        memIf.cpustate  = CPU_IDLE;
        memIf.addr      = '0;
        memIf.mem_read  = 1'b0;
        memIf.mem2bus   = 1'b0;
        memIf.mem_write = 1'b0;
        memIf.bus2mem   = 1'b0;
        memIf.bus_in    = '0;
        memIf.ld_valid  = 1'b0;
        memIf.ld_data   = '0;
        memIf.chk_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] reset during load");
        enterLoad();
        for (int i = 0; i < 3; i++) loadCycle(1'b1, 8'($urandom_range(0, 255)));
        memIf.ld_valid = 1'b1;
        rst_n = 1'b0;
        loadCount = 0;
        @(negedge clk);
        checkAllZero("midload_reset");
        memIf.cpustate = CPU_IDLE;
        #1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("idle_ld_ready", {31'd0, memIf.ld_ready}, 0);
        checkOutput("idle_load_count", {23'd0, memIf.load_count}, 0);
        tick();
        memIf.ld_valid = 1'b0;

        $display("[TB] overfill load and full readback");
        enterLoad();
        for (int i = 0; i < DEPTH + 2; i++) loadCycle(1'b1, 8'($urandom_range(0, 255)));
        @(negedge clk);
        checkOutput("overfill_load_count", {23'd0, memIf.load_count}, DEPTH);
        tick();
        doCheck(1'b0);

        $display("[TB] four byte load and stalled readback");
        enterLoad();
        loadCycle(1'b1, 8'hA5);
        loadCycle(1'b1, 8'h3C);
        loadCycle(1'b0, 8'h77);
        loadCycle(1'b1, 8'h00);
        loadCycle(1'b1, 8'hFF);
        @(negedge clk);
        checkOutput("four_load_count", {23'd0, memIf.load_count}, 4);
        tick();
        doCheck(1'b1);

        $display("[TB] RUN directed");
        enterRun();
        cpuCycle(1'b0, 1'b1, 16'h0010, 8'h5A);
        cpuCycle(1'b1, 1'b0, 16'h0010, 0);
        cpuCycle(1'b1, 1'b0, 16'h0100, 0);
        cpuCycle(1'b0, 1'b1, 16'h0100, 8'h77);
        cpuCycle(1'b1, 1'b0, 16'h0000, 0);
        cpuCycle(1'b0, 1'b1, 16'h0002, 8'hC3);
        cpuCycle(1'b1, 1'b0, 16'h0002, 0);
        cpuCycle(1'b0, 1'b1, 16'h0004, 8'h96);
        cpuCycle(1'b1, 1'b0, 16'h0004, 0);
        cpuCycle(1'b1, 1'b1, 16'h0020, 8'h11);
        cpuCycle(1'b1, 1'b0, 16'h0020, 0);
        memIf.addr     = 16'h0010;
        memIf.mem_read = 1'b1;
        @(negedge clk);
        checkOutput("bus_gate_no_mem2bus", {24'd0, memIf.bus_out}, 0);
        tick();
        memIf.mem_read = 1'b0;

        $display("[TB] RUN random");
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 65535)) : int'($urandom_range(0, DEPTH - 1));
            cpuCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 255)));
        end

        $display("[TB] strobes outside RUN");
        memIf.cpustate = CPU_IDLE;
        tick();
        inRun = 1'b0;
        cpuCycle(1'b1, 1'b1, 16'h0010, 8'h99);
        enterRun();
        cpuCycle(1'b1, 1'b0, 16'h0010, 0);

        $display("[TB] empty load then CHECK");
        enterLoad();
        memIf.cpustate  = CPU_CHECK;
        memIf.chk_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("empty_done_entry", {31'd0, memIf.chk_done}, 0);
        checkOutput("empty_valid_entry", {31'd0, memIf.chk_valid}, 0);
        tick();
        @(negedge clk);
        checkOutput("empty_done", {31'd0, memIf.chk_done}, 1);
        checkOutput("empty_valid", {31'd0, memIf.chk_valid}, 0);
        tick();
        memIf.chk_ready = 1'b0;

        tick();
        checkOutput("rd_queue_drained", rdQ.size(), 0);
        checkOutput("chk_queue_empty", chkQ.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
